// File: rtl/cv32e40p_ft_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_pkg
// Shared types for the fault-tolerant (triplicated) pipeline stages.
//   voter_state_e   : voter operating mode (TMR, DMR, terminal FAIL)
//   if_id_bundle_t  : one lane of the IF/ID pipeline register
//   IF_ID_BUNDLE_W  : width of if_id_bundle_t in bits
// ----------------------------------------------------------------------------
package cv32e40p_ft_pkg;

    // valid(1) + rdata(32) + compressed(1) + illegal(1) + pc(32) + fetch_failed(1)
    localparam int IF_ID_BUNDLE_W = 68;

    typedef enum logic [1:0] {
        VOTE_TMR  = 2'd0,
        VOTE_DMR  = 2'd1,
        VOTE_FAIL = 2'd2
    } voter_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        compressed;
        logic        illegal;
        logic [31:0] pc;
        logic        fetch_failed;
    } if_id_bundle_t;

endpackage

// File: rtl/cv32e40p_majority_voter.sv
// ----------------------------------------------------------------------------
// cv32e40p_majority_voter
// Bitwise 2-of-3 majority of three equal-width words, plus a per-lane flag
// telling whether that lane disagrees with the voted word. Purely
// combinational.
//   in_i       [2:0][WIDTH-1:0]  the three lane words
//   maj_o      [WIDTH-1:0]       bitwise majority
//   mismatch_o [2:0]             lane i differs from maj_o
// ----------------------------------------------------------------------------
module cv32e40p_majority_voter #(
    parameter int WIDTH = 1
) (
    input  logic [2:0][WIDTH-1:0] in_i,
    output logic [WIDTH-1:0]      maj_o,
    output logic [2:0]            mismatch_o
);

    assign maj_o = (in_i[0] & in_i[1]) | (in_i[0] & in_i[2]) | (in_i[1] & in_i[2]);

    assign mismatch_o[0] = (in_i[0] != maj_o);
    assign mismatch_o[1] = (in_i[1] != maj_o);
    assign mismatch_o[2] = (in_i[2] != maj_o);

endmodule

// File: rtl/cv32e40p_if_id_voter_ft.sv
// ----------------------------------------------------------------------------
// cv32e40p_if_id_voter_ft
// Votes the three IF/ID pipeline register lanes into one bundle for the
// decoder. Counts single-lane disagreements per lane, drops to DMR once a
// lane reaches THRESHOLD, raises a refetch request on uncorrectable TMR
// faults and goes permanently fatal on a DMR mismatch.
//   clk, rst_n              : clock, async active-low reset
//   *_id_i / pc_id_i [2:0]  : per-lane IF/ID bundle fields
//   refetch_ack_i           : controller has redirected the fetch
//   clear_counters_i        : synchronous clear of the error counters
//   instr_* / pc_o / ...    : voted bundle (combinational)
//   lane_err_o              : lanes disagreeing this cycle (combinational)
//   err_cnt_o               : per-lane saturating error counters
//   lane_disabled_o         : one-hot excluded lane, 0 in TMR
//   refetch_req_o, fatal_o  : refetch request / sticky fatal flag
// ----------------------------------------------------------------------------
module cv32e40p_if_id_voter_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            instr_valid_id_i,
    input  logic [2:0][31:0]      instr_rdata_id_i,
    input  logic [2:0]            is_compressed_id_i,
    input  logic [2:0]            illegal_c_insn_id_i,
    input  logic [2:0][31:0]      pc_id_i,
    input  logic [2:0]            is_fetch_failed_i,
    input  logic                  refetch_ack_i,
    input  logic                  clear_counters_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  is_compressed_o,
    output logic                  illegal_c_insn_o,
    output logic [31:0]           pc_o,
    output logic                  is_fetch_failed_o,
    output logic [2:0]            lane_err_o,
    output logic [2:0][CNT_W-1:0] err_cnt_o,
    output logic [2:0]            lane_disabled_o,
    output logic                  refetch_req_o,
    output logic                  fatal_o
);

    // A threshold the counter can never reach behaves like "never exclude".
    localparam bit              THR_EN  = (THRESHOLD > 0) && (THRESHOLD < (1 << CNT_W));
    localparam logic [CNT_W-1:0] THR_VAL = CNT_W'(THRESHOLD);

    voter_state_e                state_q, state_d;
    logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]                  dis_q, dis_d;
    logic                        req_q, req_d;
    logic                        fatal_q, fatal_d;

    if_id_bundle_t [2:0]              lane_b;
    logic [2:0][IF_ID_BUNDLE_W-1:0]   lane_bus;
    logic [IF_ID_BUNDLE_W-1:0]        maj_bits;
    logic [2:0]                       tmr_mm;
    logic [1:0]                       err_sum;
    logic [1:0]                       lo_idx, hi_idx;
    logic                             dmr_mm;
    if_id_bundle_t                    out_b;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lane_b[i].valid        = instr_valid_id_i[i];
            lane_b[i].rdata        = instr_rdata_id_i[i];
            lane_b[i].compressed   = is_compressed_id_i[i];
            lane_b[i].illegal      = illegal_c_insn_id_i[i];
            lane_b[i].pc           = pc_id_i[i];
            lane_b[i].fetch_failed = is_fetch_failed_i[i];
            lane_bus[i]            = lane_b[i];
        end
    end

    cv32e40p_majority_voter #(.WIDTH(IF_ID_BUNDLE_W)) u_voter (
        .in_i       (lane_bus),
        .maj_o      (maj_bits),
        .mismatch_o (tmr_mm)
    );

    assign err_sum = {1'b0, tmr_mm[0]} + {1'b0, tmr_mm[1]} + {1'b0, tmr_mm[2]};

    // The two surviving lanes once one is excluded; lo_idx drives the output.
    always_comb begin
        lo_idx = 2'd0;
        hi_idx = 2'd2;
        case (dis_q)
            3'b001:  begin lo_idx = 2'd1; hi_idx = 2'd2; end
            3'b100:  begin lo_idx = 2'd0; hi_idx = 2'd1; end
            default: begin lo_idx = 2'd0; hi_idx = 2'd2; end
        endcase
    end

    assign dmr_mm = (lane_bus[lo_idx] != lane_bus[hi_idx]);
    assign out_b  = (state_q == VOTE_TMR) ? if_id_bundle_t'(maj_bits) : lane_b[lo_idx];

    always_comb begin
        lane_err_o = '0;
        if (state_q == VOTE_TMR) begin
            lane_err_o = tmr_mm;
        end else if (dmr_mm) begin
            lane_err_o[lo_idx] = 1'b1;
            lane_err_o[hi_idx] = 1'b1;
        end
    end

    always_comb begin
        logic [CNT_W-1:0] cnt_inc;
        state_d = state_q;
        cnt_d   = cnt_q;
        dis_d   = dis_q;
        req_d   = req_q;
        fatal_d = fatal_q;
        cnt_inc = '0;

        unique case (state_q)
            VOTE_TMR: begin
                if (err_sum == 2'd1) begin
                    for (int i = 0; i < 3; i++) begin
                        // A saturated counter is no longer incremented, so it
                        // cannot trigger a degrade on its own.
                        if (tmr_mm[i] && (cnt_q[i] != '1) && !clear_counters_i) begin
                            cnt_inc  = cnt_q[i] + 1'b1;
                            cnt_d[i] = cnt_inc;
                            if (THR_EN && (cnt_inc == THR_VAL)) begin
                                state_d = VOTE_DMR;
                                dis_d   = tmr_mm;
                            end
                        end
                    end
                end
            end
            VOTE_DMR: begin
                if (dmr_mm) begin
                    state_d = VOTE_FAIL;
                    fatal_d = 1'b1;
                end
            end
            VOTE_FAIL: fatal_d = 1'b1;
            default:   state_d = VOTE_TMR;
        endcase

        if (clear_counters_i) cnt_d = '0;

        // Events arriving while a request is pending are absorbed.
        if (req_q)                                         req_d = ~refetch_ack_i;
        else if ((state_q == VOTE_TMR) && (err_sum >= 2'd2)) req_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VOTE_TMR;
            cnt_q   <= '0;
            dis_q   <= '0;
            req_q   <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dis_q   <= dis_d;
            req_q   <= req_d;
            fatal_q <= fatal_d;
        end
    end

    assign instr_valid_o     = out_b.valid & ~req_q & (state_q != VOTE_FAIL);
    assign instr_rdata_o     = out_b.rdata;
    assign is_compressed_o   = out_b.compressed;
    assign illegal_c_insn_o  = out_b.illegal;
    assign pc_o              = out_b.pc;
    assign is_fetch_failed_o = out_b.fetch_failed;
    assign err_cnt_o         = cnt_q;
    assign lane_disabled_o   = dis_q;
    assign refetch_req_o     = req_q;
    assign fatal_o           = fatal_q;

endmodule

// File: tb/tb_cv32e40p_if_id_voter_ft.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_if_id_voter_ft
// Two instances share the lane inputs: index 0 uses THRESHOLD=8, index 1
// uses THRESHOLD=0 (never exclude). Expected observations are queued when a
// stimulus row is driven and compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_cv32e40p_if_id_voter_ft;

    localparam logic [31:0] R = 32'h0000_0013;
    localparam logic [31:0] B = 32'h0000_0033;   // R with bit 5 flipped
    localparam logic [31:0] P = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       vl, cm, il, ff;
    logic [2:0][31:0] rd, pc;
    logic             clr, ack;

    logic             v_o[2];
    logic [31:0]      rd_o[2];
    logic             cm_o[2];
    logic             il_o[2];
    logic [31:0]      pc_o[2];
    logic             ff_o[2];
    logic [2:0]       err_o[2];
    logic [2:0][3:0]  cnt_o[2];
    logic [2:0]       dis_o[2];
    logic             req_o[2];
    logic             fat_o[2];

    cv32e40p_if_id_voter_ft #(.CNT_W(4), .THRESHOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_id_i(vl), .instr_rdata_id_i(rd), .is_compressed_id_i(cm),
        .illegal_c_insn_id_i(il), .pc_id_i(pc), .is_fetch_failed_i(ff),
        .refetch_ack_i(ack), .clear_counters_i(clr),
        .instr_valid_o(v_o[0]), .instr_rdata_o(rd_o[0]), .is_compressed_o(cm_o[0]),
        .illegal_c_insn_o(il_o[0]), .pc_o(pc_o[0]), .is_fetch_failed_o(ff_o[0]),
        .lane_err_o(err_o[0]), .err_cnt_o(cnt_o[0]), .lane_disabled_o(dis_o[0]),
        .refetch_req_o(req_o[0]), .fatal_o(fat_o[0])
    );

    cv32e40p_if_id_voter_ft #(.CNT_W(4), .THRESHOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_id_i(vl), .instr_rdata_id_i(rd), .is_compressed_id_i(cm),
        .illegal_c_insn_id_i(il), .pc_id_i(pc), .is_fetch_failed_i(ff),
        .refetch_ack_i(ack), .clear_counters_i(clr),
        .instr_valid_o(v_o[1]), .instr_rdata_o(rd_o[1]), .is_compressed_o(cm_o[1]),
        .illegal_c_insn_o(il_o[1]), .pc_o(pc_o[1]), .is_fetch_failed_o(ff_o[1]),
        .lane_err_o(err_o[1]), .err_cnt_o(cnt_o[1]), .lane_disabled_o(dis_o[1]),
        .refetch_req_o(req_o[1]), .fatal_o(fat_o[1])
    );

    typedef struct packed {
        logic            valid;
        logic [31:0]     rdata;
        logic            cmp;
        logic            ill;
        logic [31:0]     pc;
        logic            ff;
        logic [2:0]      err;
        logic [2:0][3:0] cnt;
        logic [2:0]      dis;
        logic            req;
        logic            fatal;
    } obs_t;

    typedef struct {
        string name;
        int    which;
        obs_t  exp;
    } sb_t;

    typedef struct {
        string       name;
        bit          rst;
        logic [31:0] rd0, rd1, rd2, pc0, pc1, pc2;
        logic        clr, ack;
        obs_t        exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t mk(logic v, logic [31:0] r, logic [31:0] p, logic [2:0] e,
                                logic [3:0] c2, logic [3:0] c1, logic [3:0] c0,
                                logic [2:0] d, logic q, logic f);
        obs_t o;
        o = '0;
        o.valid = v; o.rdata = r; o.pc = p; o.err = e;
        o.cnt = {c2, c1, c0}; o.dis = d; o.req = q; o.fatal = f;
        return o;
    endfunction

    function automatic obs_t act(int k);
        obs_t o;
        o.valid = v_o[k]; o.rdata = rd_o[k]; o.cmp = cm_o[k]; o.ill = il_o[k];
        o.pc = pc_o[k]; o.ff = ff_o[k]; o.err = err_o[k]; o.cnt = cnt_o[k];
        o.dis = dis_o[k]; o.req = req_o[k]; o.fatal = fat_o[k];
        return o;
    endfunction

    function automatic void row(string n, bit rs, logic [31:0] r0, logic [31:0] r1,
                                logic [31:0] r2, logic [31:0] p0, logic [31:0] p1,
                                logic [31:0] p2, logic c, logic a, obs_t e);
        tbl.push_back('{n, rs, r0, r1, r2, p0, p1, p2, c, a, e});
    endfunction

    task automatic set_clean();
        vl = 3'b111; cm = '0; il = '0; ff = '0;
        rd = {R, R, R}; pc = {P, P, P}; clr = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        set_clean();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic push(string n, int which, obs_t e);
        sb.push_back('{n, which, e});
    endtask

    task automatic apply(vec_t v);
        if (v.rst) do_reset();
        @(posedge clk); #1;
        set_clean();
        rd  = {v.rd2, v.rd1, v.rd0};
        pc  = {v.pc2, v.pc1, v.pc0};
        clr = v.clr;
        ack = v.ack;
        push(v.name, 0, v.exp);
    endtask

    // Scoreboard checker: everything queued since the last falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t  it;
            obs_t a;
            it = sb.pop_front();
            a  = act(it.which);
            n_cmp++;
            if (a !== it.exp) begin
                n_bad++;
                $display("FAIL %s dut=%0d got=%h want=%h", it.name, it.which, a, it.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        vl = '0; cm = '0; il = '0; ff = '0; rd = '0; pc = '0; clr = 1'b0; ack = 1'b0;

        // Stimulus table
        row("clean", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        for (int k = 0; k < 8; k++)
            row($sformatf("deg%0d", k), 0, R, B, R, P, P, P, 0, 0,
                mk(1, R, P, 3'b010, 0, 4'(k), 0, 3'b000, 0, 0));
        row("dmr_enter",  0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 8, 0, 3'b010, 0, 0));
        row("dmr_l1junk", 0, R, 32'hdead, R, P, 32'h44, P, 0, 0,
            mk(1, R, P, 3'b000, 0, 8, 0, 3'b010, 0, 0));
        row("dmr_pcdiff", 0, R, R, R, 32'h84, P, P, 0, 0,
            mk(1, R, 32'h84, 3'b101, 0, 8, 0, 3'b010, 0, 0));
        row("fail1", 0, R, R, R, P, P, P, 0, 0, mk(0, R, P, 3'b000, 0, 8, 0, 3'b010, 0, 1));
        row("fail2", 0, R, R, R, P, P, P, 0, 0, mk(0, R, P, 3'b000, 0, 8, 0, 3'b010, 0, 1));
        row("rst_tmr", 1, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        row("unc_ev", 0, 32'h12, R, R, P, P, 32'h90, 0, 0,
            mk(1, R, P, 3'b101, 0, 0, 0, 3'b000, 0, 0));
        row("unc_hold", 0, R, R, R, P, P, P, 0, 0, mk(0, R, P, 3'b000, 0, 0, 0, 3'b000, 1, 0));
        row("unc_ack_ev", 0, 32'h12, R, R, P, P, 32'h90, 0, 1,
            mk(0, R, P, 3'b101, 0, 0, 0, 3'b000, 1, 0));
        row("unc_done", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        row("unc3_ev", 0, 32'h1, 32'h2, 32'h4, P, P, P, 0, 0,
            mk(1, 32'h0, P, 3'b111, 0, 0, 0, 3'b000, 0, 0));
        row("unc3_hold", 0, R, R, R, P, P, P, 0, 0, mk(0, R, P, 3'b000, 0, 0, 0, 3'b000, 1, 0));
        row("unc3_ack",  0, R, R, R, P, P, P, 0, 1, mk(0, R, P, 3'b000, 0, 0, 0, 3'b000, 1, 0));
        row("unc3_done", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        row("clr_inc", 0, R, R, 32'h17, P, P, P, 1, 0, mk(1, R, P, 3'b100, 0, 0, 0, 3'b000, 0, 0));
        row("clr_won", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        row("inc2", 0, R, R, 32'h17, P, P, P, 0, 0, mk(1, R, P, 3'b100, 0, 0, 0, 3'b000, 0, 0));
        row("inc2_vis", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 1, 0, 0, 3'b000, 0, 0));
        row("clr_only", 0, R, R, R, P, P, P, 1, 0, mk(1, R, P, 3'b000, 1, 0, 0, 3'b000, 0, 0));
        row("clr_vis", 0, R, R, R, P, P, P, 0, 0, mk(1, R, P, 3'b000, 0, 0, 0, 3'b000, 0, 0));

        // Reset state with all-zero inputs
        #1;
        push("reset8", 0, mk(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        push("reset0", 1, mk(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0));
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Saturation on the never-exclude instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            set_clean();
            rd[0] = 32'h12;
            push($sformatf("sat%0d", k), 1,
                 mk(1, R, P, 3'b001, 0, 0, (k < 15) ? 4'(k) : 4'd15, 3'b000, 0, 0));
        end
        @(posedge clk); #1;
        set_clean();
        push("sat_hold", 1, mk(1, R, P, 3'b000, 0, 0, 15, 3'b000, 0, 0));
        push("thr8_dmr_l0", 0, mk(1, R, P, 3'b000, 0, 0, 8, 3'b001, 0, 0));

        // Minority compressed flag is out-voted and counted on lane 2
        @(posedge clk); #1;
        set_clean();
        cm = 3'b011;
        e = mk(1, R, P, 3'b100, 0, 0, 15, 3'b000, 0, 0);
        e.cmp = 1'b1;
        push("cmp_vote", 1, e);
        @(posedge clk); #1;
        set_clean();
        push("cmp_cnt", 1, mk(1, R, P, 3'b000, 1, 0, 15, 3'b000, 0, 0));

        @(negedge clk); #1;
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL too few comparisons: %0d", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad != 0) $display("TEST FAILED");
        else            $display("TEST PASSED");
        $finish;
    end

endmodule
